debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised multi-channel button front end: per channel 2FF synchroniser, debounce filter, press/release edge pulses and hold/auto-repeat pulses.
- Selectable input polarity; all outputs normalised active-high.
- Sits between board button pins and UI/control logic (cursor movement, mode select) in the VGA text display; replaces per-button debounce instances.

Parameters:
- NUM_CH, 4, number of independent button channels (>=1)
- CLK_FREQ, 100_000_000, clock frequency in Hz
- DEBOUNCE_MS, 20, stable time before a level change is accepted; DB = (CLK_FREQ/1000)*DEBOUNCE_MS cycles, DB >= 1 required
- HOLD_MS, 500, press duration before first hold/repeat pulse; HOLD = (CLK_FREQ/1000)*HOLD_MS cycles, HOLD >= 1
- REPEAT_MS, 100, auto-repeat period after HOLD; RPT cycles computed the same way; 0 = single long-press pulse, no repeat
- ACTIVE_LOW, 0, 1 = raw pins idle high and pressed low (all channels)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_in  in  NUM_CH  raw asynchronous button pins
- btn_level  out  NUM_CH  debounced pressed state, 1 = pressed
- btn_press  out  NUM_CH  one-cycle pulse on accepted press
- btn_release  out  NUM_CH  one-cycle pulse on accepted release
- btn_repeat  out  NUM_CH  one-cycle hold/auto-repeat pulse
- any_press  out  1  registered OR of btn_press; same cycle as the pulses

Behaviour:
- One clock domain (clk); synchronous active-high reset (rst); every register is updated only on the rising edge of clk.
- Polarity: n = btn_in XOR ACTIVE_LOW before synchronisation. Sync FFs reset to 0 (normalised inactive), so no spurious press after reset for either polarity.
- Reset: all outputs 0 and all counters 0 on the edge where rst is sampled high; rst overrides every other event.
- Debounce, per channel, with s = synchroniser output:
  - if s == btn_level: dcount <= 0
  - else if dcount == DB-1: btn_level <= s, dcount <= 0
  - else: dcount <= dcount+1
- Latency: t0 = first edge at which btn_in is sampled active and held stable. btn_level changes on edge t0+DB+1.
- Glitch rejection: any mismatch lasting fewer than DB synchronised cycles produces no output change; the counter restarts from 0 on every return to agreement.
- btn_press / btn_release: registered on the same edge as the btn_level 0->1 / 1->0 update. High for exactly one cycle, coincident with the first cycle of the new level.
- Hold FSM per channel, states RELEASED, HELD, REPEATING; hcount counts cycles in HELD/REPEATING.
  - RELEASED -> HELD on the press edge; hcount <= 0.
  - HELD: when hcount == HOLD-1, pulse btn_repeat. If RPT > 0, go to REPEATING with hcount <= 0; else stay in HELD with hcount frozen, so only one pulse is emitted.
  - REPEATING: pulse btn_repeat each time hcount == RPT-1, then hcount <= 0.
  - Any state -> RELEASED on the release edge; hcount <= 0.
  - If release and a terminal count fall on the same edge, release wins: no btn_repeat pulse.
- Resulting timing, with tp = press edge: first btn_repeat on edge tp+HOLD, then tp+HOLD+k*RPT for k >= 1.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset while a button is held: after rst drops, the held button is reported as a fresh press DB+1 edges after the first post-reset sampling edge.
- Widths: dcount is $clog2(DB+1) bits; hcount is $clog2(max(HOLD,RPT)+1) bits. No counter wraps; each is cleared at its terminal count.

Decomposition:
- Shared package/include holds: ms-to-cycles constant function, FSM state encodings (2 bits: RELEASED=0, HELD=1, REPEATING=2), counter width helper.
- One sub-module, debounce_channel: a single channel containing synchroniser, debounce counter, hold FSM and pulse registers. Instantiated NUM_CH times in a generate loop.
- Top level contains only the polarity XOR, the generate loop and the any_press register.

Test Plan:
All tests use CLK_FREQ=1000 (1 cycle/ms), NUM_CH=2, DEBOUNCE_MS=4, HOLD_MS=10, REPEAT_MS=3, ACTIVE_LOW=0 unless stated.
1. ch0 btn_in high from edge 0, held -> btn_level[0] and btn_press[0] high after edge 5, press high 1 cycle only; btn_repeat[0] pulses at edges 15, 18, 21, ...
2. ch0 high for 3 cycles then low -> btn_level stays 0 with no pulses. Then high for 4 stable cycles (>= DB) -> press accepted.
3. Press held 8 cycles after btn_press, then released -> btn_release pulse on edge release_sample+5, no btn_repeat. Repeat the test with REPEAT_MS=0 and hold 30 cycles -> exactly one btn_repeat, at tp+10.
4. ACTIVE_LOW=1, pins idle 1 through and after reset -> all outputs 0. Pin driven 0 from edge 0 -> press after edge 5.
5. rst asserted during REPEATING -> all outputs 0 on that edge; button still held, rst released, first sample at edge r -> fresh btn_press at edge r+5.
6. ch0 and ch1 pressed on the same edge -> both btn_press bits and any_press high in the same single cycle; ch1 released while ch0 held -> ch0 repeat schedule unaffected.

Source files
------------

// File: rtl/debounce_bank_pkg.sv
// debounce_bank_pkg: shared constants and helpers for the button front end.
// Provides the ms-to-cycles conversion, counter width helpers and the
// hold/auto-repeat FSM state encoding used by every channel.
package debounce_bank_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } hold_state_t;

    // Converts a duration in milliseconds to clock cycles.
    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must be able to hold the value 'terminal'.
    function automatic int cnt_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel (2FF sync, debounce, edge pulses, hold/auto-repeat).
// Ports: clk, rst (sync, active-high), pin (polarity-normalised raw input),
//        level/press_pulse/rel_pulse/rpt_pulse (registered outputs), press_nxt (combinational press strobe).
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int DB   = 4,
    parameter int HOLD = 10,
    parameter int RPT  = 3
)
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic rel_pulse,
    output logic rpt_pulse,
    output logic press_nxt
);

    localparam int DW = cnt_width(DB);
    localparam int HW = cnt_width(max2(HOLD, RPT));

    localparam logic [DW-1:0] DB_LAST   = DW'(DB - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    // Parking value for the single long-press mode: one past the terminal
    // count, so the pulse condition can never match again while held.
    localparam logic [HW-1:0] HOLD_PARK = HW'(HOLD);
    localparam logic [HW-1:0] RPT_LAST  = HW'((RPT > 0) ? RPT - 1 : 0);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] dcount;
    logic          accept;
    logic          rel_nxt;
    logic          rpt_nxt;

    hold_state_t   state_q;
    hold_state_t   state_d;
    logic [HW-1:0] hcount_q;
    logic [HW-1:0] hcount_d;

    // Synchroniser resets to the inactive level so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    assign accept    = (sync2 != level) && (dcount == DB_LAST);
    assign press_nxt = accept && sync2;
    assign rel_nxt   = accept && !sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= 1'b0;
            dcount      <= '0;
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
        end else begin
            press_pulse <= press_nxt;
            rel_pulse   <= rel_nxt;
            if (sync2 == level) begin
                dcount <= '0;
            end else if (dcount == DB_LAST) begin
                level  <= sync2;
                dcount <= '0;
            end else begin
                dcount <= dcount + 1'b1;
            end
        end
    end

    // Hold FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RELEASED;
            hcount_q  <= '0;
            rpt_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcount_q  <= hcount_d;
            rpt_pulse <= rpt_nxt;
        end
    end

    // Hold FSM: next state. A release on the same edge as a terminal count wins.
    always_comb begin
        state_d  = state_q;
        hcount_d = hcount_q;
        if (rel_nxt) begin
            state_d  = ST_RELEASED;
            hcount_d = '0;
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    if (press_nxt) begin
                        state_d  = ST_HELD;
                        hcount_d = '0;
                    end
                end
                ST_HELD: begin
                    if (hcount_q == HOLD_LAST) begin
                        if (RPT > 0) begin
                            state_d  = ST_REPEATING;
                            hcount_d = '0;
                        end else begin
                            hcount_d = HOLD_PARK;
                        end
                    end else if (hcount_q != HOLD_PARK) begin
                        hcount_d = hcount_q + 1'b1;
                    end
                end
                ST_REPEATING: begin
                    if (hcount_q == RPT_LAST) begin
                        hcount_d = '0;
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_RELEASED;
                    hcount_d = '0;
                end
            endcase
        end
    end

    // Hold FSM: outputs
    always_comb begin
        rpt_nxt = 1'b0;
        if (!rel_nxt) begin
            case (state_q)
                ST_HELD:      rpt_nxt = (hcount_q == HOLD_LAST);
                ST_REPEATING: rpt_nxt = (hcount_q == RPT_LAST);
                default:      rpt_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel button front end with selectable pin polarity.
// Ports: clk, rst (sync, active-high), btn_in[NUM_CH] raw pins; btn_level, btn_press,
//        btn_release, btn_repeat per channel (active-high), any_press (OR of btn_press, same cycle).
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100,
    parameter int ACTIVE_LOW  = 0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_repeat,
    output logic              any_press
);

    localparam int DB   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int HOLD = ms_to_cycles(CLK_FREQ, HOLD_MS);
    localparam int RPT  = ms_to_cycles(CLK_FREQ, REPEAT_MS);

    logic [NUM_CH-1:0] pin_n;
    logic [NUM_CH-1:0] press_nxt;

    assign pin_n = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DB   (DB),
            .HOLD (HOLD),
            .RPT  (RPT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .pin         (pin_n[g]),
            .level       (btn_level[g]),
            .press_pulse (btn_press[g]),
            .rel_pulse   (btn_release[g]),
            .rpt_pulse   (btn_repeat[g]),
            .press_nxt   (press_nxt[g])
        );
    end

    // Registered from the channels' press strobes so it lines up with btn_press.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    localparam int NI   = 3;
    localparam int DB   = 4;
    localparam int HOLD = 10;

    function automatic int rpt_of(input int i);
        return (i == 1) ? 0 : 3;
    endfunction

    function automatic bit al_of(input int i);
        return (i == 2);
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] b    [NI];
    logic [1:0] lvl  [NI];
    logic [1:0] prs  [NI];
    logic [1:0] rls  [NI];
    logic [1:0] rpt  [NI];
    logic       anyp [NI];

    always #5 clk = ~clk;

    debounce_bank #(.NUM_CH(2), .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10),
                    .REPEAT_MS(3), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .btn_in(b[0]), .btn_level(lvl[0]), .btn_press(prs[0]),
        .btn_release(rls[0]), .btn_repeat(rpt[0]), .any_press(anyp[0]));

    debounce_bank #(.NUM_CH(2), .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10),
                    .REPEAT_MS(0), .ACTIVE_LOW(0)) dut_nr (
        .clk(clk), .rst(rst), .btn_in(b[1]), .btn_level(lvl[1]), .btn_press(prs[1]),
        .btn_release(rls[1]), .btn_repeat(rpt[1]), .any_press(anyp[1]));

    debounce_bank #(.NUM_CH(2), .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10),
                    .REPEAT_MS(3), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .btn_in(b[2]), .btn_level(lvl[2]), .btn_press(prs[2]),
        .btn_release(rls[2]), .btn_repeat(rpt[2]), .any_press(anyp[2]));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle)", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A level flips once the last DB synchronised samples (pin samples delayed
    // by two edges) all disagree with it. Repeats follow from the press time.
    int  cyc      = 0;
    bit  model_ok = 0;
    bit [1:0] e_lvl [NI];
    bit [1:0] e_prs [NI];
    bit [1:0] e_rls [NI];
    bit [1:0] e_rpt [NI];
    bit       e_any [NI];
    bit       hq    [NI][2][$];
    int       tp    [NI][2];

    always @(posedge clk) begin
        cyc++;
        if (rst) model_ok = 1;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 2; c++) begin
                e_prs[i][c] = 1'b0;
                e_rls[i][c] = 1'b0;
                e_rpt[i][c] = 1'b0;
                if (rst) begin
                    hq[i][c].delete();
                    for (int k = 0; k < DB + 2; k++) hq[i][c].push_front(1'b0);
                    e_lvl[i][c] = 1'b0;
                end else begin
                    bit flip;
                    int d;
                    hq[i][c].push_front(b[i][c] ^ al_of(i));
                    if (hq[i][c].size() > 32) void'(hq[i][c].pop_back());
                    flip = (hq[i][c].size() >= DB + 2);
                    if (flip) begin
                        for (int j = 0; j < DB; j++)
                            if (hq[i][c][2+j] == e_lvl[i][c]) flip = 1'b0;
                    end
                    if (flip) begin
                        if (e_lvl[i][c] == 1'b0) begin
                            e_prs[i][c] = 1'b1;
                            tp[i][c] = cyc;
                        end else begin
                            e_rls[i][c] = 1'b1;
                        end
                        e_lvl[i][c] = ~e_lvl[i][c];
                    end
                    if (e_lvl[i][c] && !e_prs[i][c]) begin
                        d = cyc - tp[i][c];
                        if (d == HOLD || (rpt_of(i) > 0 && d > HOLD && ((d - HOLD) % rpt_of(i)) == 0))
                            e_rpt[i][c] = 1'b1;
                    end
                end
            end
            e_any[i] = rst ? 1'b0 : |e_prs[i];
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("m i%0d lvl @%0d", i, cyc), lvl[i], e_lvl[i]);
                chk($sformatf("m i%0d prs @%0d", i, cyc), prs[i], e_prs[i]);
                chk($sformatf("m i%0d rls @%0d", i, cyc), rls[i], e_rls[i]);
                chk($sformatf("m i%0d rpt @%0d", i, cyc), rpt[i], e_rpt[i]);
                chk($sformatf("m i%0d any @%0d", i, cyc), anyp[i], e_any[i]);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step_to(input int target);
        while (cyc < target) @(negedge clk);
        if (cyc != target) chk("step overrun", cyc, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int t0, t1, r, nrep, rep_at;
        rst  = 1'b1;
        b[0] = 2'b00;
        b[1] = 2'b00;
        b[2] = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst lvl", lvl[0], 0);
        chk("rst any", anyp[0], 0);
        chk("rst al lvl", lvl[2], 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("al idle lvl", lvl[2], 0);
        chk("al idle prs", prs[2], 0);

        // Press held: latency and repeat schedule; active-low channel in parallel
        b[0][0] = 1'b1; b[2][0] = 1'b0; t0 = cyc + 1;
        step_to(t0 + 4);  chk("t1 lvl before", lvl[0][0], 0);
        step_to(t0 + 5);  chk("t1 press", prs[0][0], 1); chk("t1 lvl", lvl[0][0], 1);
                          chk("t1 any", anyp[0], 1); chk("t4 al press", prs[2][0], 1);
        step_to(t0 + 6);  chk("t1 press 1cyc", prs[0][0], 0); chk("t1 lvl held", lvl[0][0], 1);
        step_to(t0 + 14); chk("t1 rpt early", rpt[0][0], 0);
        step_to(t0 + 15); chk("t1 rpt first", rpt[0][0], 1);
        step_to(t0 + 16); chk("t1 rpt 1cyc", rpt[0][0], 0);
        step_to(t0 + 18); chk("t1 rpt second", rpt[0][0], 1);
        step_to(t0 + 21); chk("t1 rpt third", rpt[0][0], 1);
        b[0][0] = 1'b0; b[2][0] = 1'b1; t1 = cyc + 1;
        step_to(t1 + 5);  chk("t1 release", rls[0][0], 1); chk("t1 lvl off", lvl[0][0], 0);
        step_to(t1 + 12);

        // Glitch of 3 samples rejected, then 4 samples accepted
        b[0][0] = 1'b1; t0 = cyc + 1;
        step_to(t0 + 2);  b[0][0] = 1'b0;
        step_to(t0 + 12); chk("t2 glitch lvl", lvl[0][0], 0);
        b[0][0] = 1'b1; t0 = cyc + 1;
        step_to(t0 + 3);  b[0][0] = 1'b0;
        step_to(t0 + 5);  chk("t2 press", prs[0][0], 1);
        step_to(t0 + 9);  chk("t2 release", rls[0][0], 1);
        step_to(t0 + 15);

        // 8-sample press: release 5 edges after release sample, no repeat
        b[0][0] = 1'b1; t0 = cyc + 1; nrep = 0;
        for (int k = t0; k <= t0 + 18; k++) begin
            step_to(k);
            nrep += int'(rpt[0][0]);
            if (k == t0 + 7) b[0][0] = 1'b0;
            if (k == t0 + 13) chk("t3 release", rls[0][0], 1);
        end
        chk("t3 no repeat", nrep, 0);

        // 10-sample press: release coincides with hold terminal count
        b[0][0] = 1'b1; t0 = cyc + 1; nrep = 0;
        for (int k = t0; k <= t0 + 20; k++) begin
            step_to(k);
            nrep += int'(rpt[0][0]);
            if (k == t0 + 9) b[0][0] = 1'b0;
            if (k == t0 + 15) chk("t3 release wins", rls[0][0], 1);
        end
        chk("t3 release wins no rpt", nrep, 0);

        // Single long-press pulse when repeat period is zero
        b[1][0] = 1'b1; t0 = cyc + 1; nrep = 0; rep_at = -1;
        for (int k = t0; k <= t0 + 45; k++) begin
            step_to(k);
            if (rpt[1][0]) begin
                nrep++;
                rep_at = k - t0;
            end
            if (k == t0 + 29) b[1][0] = 1'b0;
        end
        chk("t3 nr count", nrep, 1);
        chk("t3 nr pos", rep_at, 15);

        // Reset while repeating, button still held
        b[0][0] = 1'b1; t0 = cyc + 1;
        step_to(t0 + 18); chk("t5 rpt before rst", rpt[0][0], 1);
        rst = 1'b1;
        step_to(t0 + 19); chk("t5 rst lvl", lvl[0], 0); chk("t5 rst rpt", rpt[0], 0);
                          chk("t5 rst prs", prs[0], 0); chk("t5 rst rls", rls[0], 0);
                          chk("t5 rst any", anyp[0], 0);
        step_to(t0 + 20); rst = 1'b0; r = cyc + 1;
        step_to(r + 4);   chk("t5 no early press", lvl[0][0], 0);
        step_to(r + 5);   chk("t5 fresh press", prs[0][0], 1);
        b[0][0] = 1'b0;
        step_to(cyc + 12);

        // Simultaneous press on both channels, ch1 released early
        b[0] = 2'b11; t0 = cyc + 1;
        step_to(t0 + 5);  chk("t6 both press", prs[0], 3); chk("t6 any", anyp[0], 1);
        step_to(t0 + 6);  chk("t6 press 1cyc", prs[0], 0); chk("t6 any 1cyc", anyp[0], 0);
                          b[0][1] = 1'b0;
        step_to(t0 + 12); chk("t6 ch1 release", rls[0], 2);
        step_to(t0 + 15); chk("t6 ch0 rpt", rpt[0], 1);
        step_to(t0 + 18); chk("t6 ch0 rpt2", rpt[0], 1);
        b[0] = 2'b00;
        step_to(cyc + 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
